// File: rtl/enemy_move_ctrl.sv
// enemy_move_ctrl: per-enemy grid walker producing sprite position and facing.
// Steps once per frame, backs off and re-routes on a leading-edge wall hit or
// at the play-field bounds. Optional random turns at tile intersections are
// compiled in with the macro ENEMY_RANDOM_TURN_EN.
module enemy_move_ctrl #(
    parameter logic [10:0] INITIAL_X = 11'd64,
    parameter logic [10:0] INITIAL_Y = 11'd64,
    parameter int unsigned SPEED     = 1,
    parameter logic [10:0] X_MIN     = 11'd32,
    parameter logic [10:0] X_MAX     = 11'd576,
    parameter logic [10:0] Y_MIN     = 11'd32,
    parameter logic [10:0] Y_MAX     = 11'd416,
    parameter logic [7:0]  SEED      = 8'hA5
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        collision,
    input  logic [3:0]  HitEdgeCode,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [3:0]  direction,
    output logic        turnPulse
);

    localparam logic [10:0] STEP       = 11'(SPEED);
    localparam logic [3:0]  DIR_LEFT   = 4'b1000;
    localparam logic [3:0]  DIR_TOP    = 4'b0100;
    localparam logic [3:0]  DIR_RIGHT  = 4'b0010;
    localparam logic [3:0]  DIR_BOTTOM = 4'b0001;

    typedef enum logic {S_MOVE, S_CHOOSE} state_e;

    state_e      state_q, state_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic [3:0]  direction_q, direction_d;
    logic [3:0]  blocked_q, blocked_d;
    logic        turn_pulse_q, turn_pulse_d;
    logic        hit_flag_q, hit_flag_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        hit_now;
    logic        at_bound;
    logic [3:0]  candidate;

    // Next-state, motion and direction-choice logic
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        direction_d  = direction_q;
        blocked_d    = blocked_q;
        turn_pulse_d = 1'b0;
        lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        hit_now    = collision && ((HitEdgeCode & direction_q) != '0);
        hit_flag_d = enable ? (hit_flag_q | hit_now) : 1'b0;

        // Pre-step comparison against MIN+STEP / MAX-STEP avoids unsigned wrap
        unique case (direction_q)
            DIR_LEFT:   at_bound = (x_q < X_MIN + STEP);
            DIR_RIGHT:  at_bound = (x_q > X_MAX - STEP);
            DIR_TOP:    at_bound = (y_q < Y_MIN + STEP);
            DIR_BOTTOM: at_bound = (y_q > Y_MAX - STEP);
            default:    at_bound = 1'b0;
        endcase

        unique case (lfsr_q[1:0])
            2'd0:    candidate = DIR_LEFT;
            2'd1:    candidate = DIR_RIGHT;
            2'd2:    candidate = DIR_TOP;
            default: candidate = DIR_BOTTOM;
        endcase
        if (candidate == blocked_q) begin
            unique case (candidate)
                DIR_LEFT:  candidate = DIR_TOP;
                DIR_TOP:   candidate = DIR_RIGHT;
                DIR_RIGHT: candidate = DIR_BOTTOM;
                default:   candidate = DIR_LEFT;
            endcase
        end

        unique case (state_q)
            S_MOVE: begin
                if (startOfFrame && enable) begin
                    hit_flag_d = 1'b0;
                    if (hit_flag_q || hit_now) begin
                        // Back off one step, opposite to the current motion
                        unique case (direction_q)
                            DIR_LEFT:   x_d = x_q + STEP;
                            DIR_RIGHT:  x_d = x_q - STEP;
                            DIR_TOP:    y_d = y_q + STEP;
                            DIR_BOTTOM: y_d = y_q - STEP;
                            default:    ;
                        endcase
                        blocked_d = direction_q;
                        state_d   = S_CHOOSE;
                    end else if (at_bound) begin
                        blocked_d = direction_q;
                        state_d   = S_CHOOSE;
                    end else begin
                        unique case (direction_q)
                            DIR_LEFT:   x_d = x_q - STEP;
                            DIR_RIGHT:  x_d = x_q + STEP;
                            DIR_TOP:    y_d = y_q - STEP;
                            DIR_BOTTOM: y_d = y_q + STEP;
                            default:    ;
                        endcase
`ifdef ENEMY_RANDOM_TURN_EN
                        if ((x_d[4:0] == '0) && (y_d[4:0] == '0) && (lfsr_q[2:0] == '0)) begin
                            blocked_d = '0;
                            state_d   = S_CHOOSE;
                        end
`endif
                    end
                end
            end
            S_CHOOSE: begin
                direction_d  = candidate;
                turn_pulse_d = 1'b1;
                blocked_d    = '0;
                state_d      = S_MOVE;
            end
            default: state_d = S_MOVE;
        endcase
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q      <= S_MOVE;
            x_q          <= INITIAL_X;
            y_q          <= INITIAL_Y;
            direction_q  <= DIR_LEFT;
            blocked_q    <= '0;
            turn_pulse_q <= 1'b0;
            hit_flag_q   <= 1'b0;
            lfsr_q       <= SEED;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            direction_q  <= direction_d;
            blocked_q    <= blocked_d;
            turn_pulse_q <= turn_pulse_d;
            hit_flag_q   <= hit_flag_d;
            lfsr_q       <= lfsr_d;
        end
    end

    assign topLeftX  = x_q;
    assign topLeftY  = y_q;
    assign direction = direction_q;
    assign turnPulse = turn_pulse_q;

endmodule

// File: tb/tb_enemy_move_ctrl.sv
// Directed bench for enemy_move_ctrl (default build, random turns disabled).
module tb_enemy_move_ctrl;

    localparam logic [3:0] L = 4'b1000;
    localparam logic [3:0] T = 4'b0100;
    localparam logic [3:0] R = 4'b0010;
    localparam logic [3:0] B = 4'b0001;
    localparam logic [7:0] SEED = 8'hA5;

    logic        clk = 1'b0;
    logic        resetN, sof, en, col;
    logic [3:0]  hec;
    logic [10:0] x, y, bx, by;
    logic [3:0]  dir, bdir;
    logic        tp, btp;
    int unsigned cyc = 0;
    int          nchk = 0;
    int          nfail = 0;

    typedef struct {
        logic        sof;
        logic        en;
        logic        col;
        logic [3:0]  hec;
        logic [10:0] x;
        logic [10:0] y;
        logic [3:0]  dir;
        logic        tp;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    // cycles since reset release; the LFSR after edge n holds SEED advanced n times
    always @(posedge clk) cyc <= resetN ? 0 : cyc + 1;

    enemy_move_ctrl u_dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en),
        .collision(col), .HitEdgeCode(hec),
        .topLeftX(x), .topLeftY(y), .direction(dir), .turnPulse(tp)
    );

    enemy_move_ctrl #(.INITIAL_X(11'd32)) u_bnd (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en),
        .collision(col), .HitEdgeCode(hec),
        .topLeftX(bx), .topLeftY(by), .direction(bdir), .turnPulse(btp)
    );

    function automatic logic [7:0] lfsr_adv(input int unsigned n);
        logic [7:0] l = SEED;
        for (int unsigned i = 0; i < n; i++)
            l = {l[6:0], ^(l & 8'hB8)};
        return l;
    endfunction

    function automatic logic [3:0] exp_choose(input logic [7:0] l, input logic [3:0] blocked);
        logic [3:0] c;
        logic [3:0] tbl [4] = '{L, R, T, B};
        logic [3:0] rot [4] = '{T, B, R, L};  // next for L, R, T, B
        c = tbl[l[1:0]];
        if (c == blocked) begin
            for (int k = 0; k < 4; k++)
                if (tbl[k] == c) return rot[k];
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic s, input logic e, input logic c, input logic [3:0] h);
        sof = s; en = e; col = c; hec = h;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b1;
        tick(0, 1, 0, 4'h0);
        tick(0, 1, 0, 4'h0);
        resetN = 1'b0;
    endtask

    logic [3:0]  d1, d2;
    logic [10:0] ex, ey;

    initial begin
        resetN = 1'b1; sof = 0; en = 1; col = 0; hec = '0;

        // free motion, leading/non-leading hits and enable=0, one record per cycle
        for (int k = 0; k < 10; k++) begin
            vq.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 11'(63 - k), 11'd64, L, 1'b0});
            vq.push_back('{1'b0, 1'b1, 1'b0, 4'h0, 11'(63 - k), 11'd64, L, 1'b0});
        end
        vq.push_back('{1'b1, 1'b1, 1'b1, B, 11'd53, 11'd64, L, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 4'h0, 11'd53, 11'd64, L, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b1, B, 11'd53, 11'd64, L, 1'b0});
        vq.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 11'd52, 11'd64, L, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 4'h0, 11'd52, 11'd64, L, 1'b0});
        for (int k = 0; k < 5; k++) begin
            vq.push_back('{1'b0, 1'b0, 1'b1, L, 11'd52, 11'd64, L, 1'b0});
            vq.push_back('{1'b1, 1'b0, 1'b1, L, 11'd52, 11'd64, L, 1'b0});
        end
        vq.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 11'd51, 11'd64, L, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 4'h0, 11'd51, 11'd64, L, 1'b0});

        // reset state of both instances
        do_reset();
        chk("reset_x", 32'(x), 32'd64);
        chk("reset_y", 32'(y), 32'd64);
        chk("reset_dir", 32'(dir), 32'(L));
        chk("reset_tp", 32'(tp), 32'd0);
        chk("reset_bx", 32'(bx), 32'd32);

        // bound: instance at X_MIN moving LEFT holds position and re-routes
        tick(1, 1, 0, 4'h0);
        chk("bnd_x_hold", 32'(bx), 32'd32);
        chk("bnd_dir_pre", 32'(bdir), 32'(L));
        chk("bnd_tp_pre", 32'(btp), 32'd0);
        chk("main_x_first", 32'(x), 32'd63);
        tick(0, 1, 0, 4'h0);
        chk("bnd_tp", 32'(btp), 32'd1);
        chk("bnd_dir", 32'(bdir), 32'(exp_choose(lfsr_adv(cyc - 1), L)));
        chk("bnd_dir_not_left", 32'(bdir != L), 32'd1);
        chk("bnd_x_post", 32'(bx), 32'd32);
        tick(0, 1, 0, 4'h0);
        chk("bnd_tp_one_cycle", 32'(btp), 32'd0);

        // table-driven vectors from a fresh reset
        do_reset();
        foreach (vq[i]) begin
            tick(vq[i].sof, vq[i].en, vq[i].col, vq[i].hec);
            chk($sformatf("vec%0d_x", i), 32'(x), 32'(vq[i].x));
            chk($sformatf("vec%0d_y", i), 32'(y), 32'(vq[i].y));
            chk($sformatf("vec%0d_dir", i), 32'(dir), 32'(vq[i].dir));
            chk($sformatf("vec%0d_tp", i), 32'(tp), 32'(vq[i].tp));
        end

        // latched hit from an earlier cycle is applied at the next frame
        tick(0, 1, 1, L);
        chk("latch_x_idle", 32'(x), 32'd51);
        tick(1, 1, 0, 4'h0);
        chk("latch_x_back", 32'(x), 32'd52);
        chk("latch_tp_pre", 32'(tp), 32'd0);
        tick(1, 1, 0, 4'h0);  // frame during CHOOSE is dropped
        d1 = exp_choose(lfsr_adv(cyc - 1), L);
        chk("latch_x_choose", 32'(x), 32'd52);
        chk("latch_tp", 32'(tp), 32'd1);
        chk("latch_dir", 32'(dir), 32'(d1));
        chk("latch_dir_not_left", 32'(dir != L), 32'd1);
        tick(0, 1, 0, 4'h0);
        chk("latch_tp_low", 32'(tp), 32'd0);
        tick(1, 1, 0, 4'h0);
        ex = (d1 == R) ? 11'd53 : 11'd52;
        ey = (d1 == T) ? 11'd63 : (d1 == B) ? 11'd65 : 11'd64;
        chk("newdir_step_x", 32'(x), 32'(ex));
        chk("newdir_step_y", 32'(y), 32'(ey));

        // wall hit coinciding with the frame pulse
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tick(1, 1, 0, 4'h0);
            tick(0, 1, 0, 4'h0);
        end
        chk("wall_x_pre", 32'(x), 32'd61);
        tick(1, 1, 1, L);
        chk("wall_x_back", 32'(x), 32'd62);
        chk("wall_tp_pre", 32'(tp), 32'd0);
        tick(0, 1, 0, 4'h0);
        d2 = exp_choose(lfsr_adv(cyc - 1), L);
        chk("wall_tp", 32'(tp), 32'd1);
        chk("wall_dir", 32'(dir), 32'(d2));
        chk("wall_dir_not_left", 32'(dir != L), 32'd1);
        tick(0, 1, 0, 4'h0);
        chk("wall_tp_low", 32'(tp), 32'd0);

        // reset while CHOOSE is pending: no pulse, all state restored
        tick(1, 1, 1, d2);
        ex = (d2 == R) ? 11'd61 : 11'd62;
        ey = (d2 == T) ? 11'd65 : (d2 == B) ? 11'd63 : 11'd64;
        chk("rst_mid_back_x", 32'(x), 32'(ex));
        chk("rst_mid_back_y", 32'(y), 32'(ey));
        resetN = 1'b1;
        tick(0, 1, 0, 4'h0);
        resetN = 1'b0;
        chk("rst_mid_x", 32'(x), 32'd64);
        chk("rst_mid_y", 32'(y), 32'd64);
        chk("rst_mid_dir", 32'(dir), 32'(L));
        chk("rst_mid_tp", 32'(tp), 32'd0);
        tick(0, 1, 0, 4'h0);
        chk("rst_mid_tp_after", 32'(tp), 32'd0);
        chk("rst_mid_dir_after", 32'(dir), 32'(L));

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
